// File: rtl/hp48_bus_ctrl.sv
`default_nettype none
// ============================================================================
// hp48_bus_ctrl - HP48 nibble-bus master; shadows slave PC/DP to skip LOADs.
// Rev 1.0
// ============================================================================
module hp48_bus_ctrl (
  input  logic        strobe_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic        req_use_dp_i,
  input  logic [19:0] req_addr_i,
  input  logic [3:0]  req_count_i,
  input  logic [63:0] req_wdata_i,
  output logic        done_o,
  output logic [63:0] rd_data_o,
  output logic        err_o,
  output logic [3:0]  bus_command_o,
  output logic [19:0] bus_address_o,
  output logic [3:0]  bus_nibble_out_o,
  input  logic [3:0]  bus_nibble_in_i,
  input  logic        bus_active_i
);

  localparam logic [3:0] c_CMD_NOP       = 4'h0;
  localparam logic [3:0] c_CMD_PC_READ   = 4'h2;
  localparam logic [3:0] c_CMD_DP_READ   = 4'h3;
  localparam logic [3:0] c_CMD_PC_WRITE  = 4'h4;
  localparam logic [3:0] c_CMD_DP_WRITE  = 4'h5;
  localparam logic [3:0] c_CMD_LOAD_PC   = 4'h6;
  localparam logic [3:0] c_CMD_LOAD_DP   = 4'h7;
  localparam logic [3:0] c_CMD_CONFIGURE = 4'h8;
  localparam logic [3:0] c_CMD_RESET     = 4'h9;

  localparam logic [1:0] c_OP_READ  = 2'd0;
  localparam logic [1:0] c_OP_WRITE = 2'd1;
  localparam logic [1:0] c_OP_CONF  = 2'd2;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_LOAD  = 3'd1;
  localparam logic [2:0] c_ST_XFER  = 3'd2;
  localparam logic [2:0] c_ST_DRAIN = 3'd3;
  localparam logic [2:0] c_ST_CONF  = 3'd4;
  localparam logic [2:0] c_ST_RST   = 3'd5;
  localparam logic [2:0] c_ST_DONE  = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        use_dp_q, use_dp_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] wdata_q, wdata_d;
  logic [3:0]  cmd_idx_q, cmd_idx_d;
  logic [19:0] pc_q, pc_d, dp_q, dp_d;
  logic        pc_vld_q, pc_vld_d, dp_vld_q, dp_vld_d;
  logic        cap_q, cap_d;
  logic [3:0]  cap_idx_q, cap_idx_d;
  logic [63:0] rbuf_q, rbuf_d;
  logic        err_acc_q, err_acc_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [19:0] baddr_q, baddr_d;
  logic [3:0]  bnib_q, bnib_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [63:0] rd_q, rd_d;
  logic        ready_q, ready_d;

  logic        w_idle;
  logic        w_accept;
  logic        w_hit;
  logic        w_dp;
  logic        w_wr;
  logic [63:0] w_wdata;
  logic [19:0] w_ptr;
  logic [3:0]  w_nidx;

  assign w_idle   = (state_q == c_ST_IDLE);
  assign w_accept = w_idle && req_valid_i;
  assign w_hit    = req_use_dp_i ? (dp_vld_q && (dp_q == req_addr_i))
                                 : (pc_vld_q && (pc_q == req_addr_i));
  // In IDLE the first transfer nibble may be issued straight from the request.
  assign w_dp     = w_idle ? req_use_dp_i : use_dp_q;
  assign w_wr     = w_idle ? (req_op_i == c_OP_WRITE) : (op_q == c_OP_WRITE);
  assign w_wdata  = w_idle ? req_wdata_i : wdata_q;
  assign w_ptr    = w_dp ? dp_q : pc_q;
  assign w_nidx   = (state_q == c_ST_XFER) ? (cmd_idx_q + 4'd1) : 4'd0;

  always_ff @(posedge strobe_i) begin
    if (reset_i) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (req_valid_i) begin
          case (req_op_i)
            c_OP_READ, c_OP_WRITE: state_d = w_hit ? c_ST_XFER : c_ST_LOAD;
            c_OP_CONF:             state_d = c_ST_CONF;
            default:               state_d = c_ST_RST;
          endcase
        end
      end
      c_ST_LOAD: state_d = c_ST_XFER;
      c_ST_XFER: begin
        if (cmd_idx_q == cnt_q) begin
          state_d = (op_q == c_OP_READ) ? c_ST_DRAIN : c_ST_DONE;
        end
      end
      c_ST_DRAIN, c_ST_CONF, c_ST_RST: state_d = c_ST_DONE;
      c_ST_DONE: state_d = c_ST_IDLE;
      default:   state_d = c_ST_IDLE;
    endcase
  end

  always_comb begin
    op_d      = op_q;
    use_dp_d  = use_dp_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    cmd_idx_d = cmd_idx_q;
    pc_d      = pc_q;
    dp_d      = dp_q;
    pc_vld_d  = pc_vld_q;
    dp_vld_d  = dp_vld_q;
    cap_d     = (cmd_q == c_CMD_PC_READ) || (cmd_q == c_CMD_DP_READ);
    cap_idx_d = cmd_idx_q;
    rbuf_d    = rbuf_q;
    err_acc_d = err_acc_q;
    cmd_d     = c_CMD_NOP;
    baddr_d   = baddr_q;
    bnib_d    = bnib_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd_d      = rd_q;
    ready_d   = (state_d == c_ST_IDLE);

    // Slave data arrives the cycle after its READ command.
    if (cap_q) begin
      rbuf_d[{cap_idx_q, 2'b00} +: 4] = bus_nibble_in_i;
    end
    if ((state_q == c_ST_XFER) && !bus_active_i) begin
      err_acc_d = 1'b1;
    end
    if (w_accept) begin
      op_d      = req_op_i;
      use_dp_d  = req_use_dp_i;
      cnt_d     = req_count_i;
      wdata_d   = req_wdata_i;
      rbuf_d    = '0;
      err_acc_d = 1'b0;
    end

    case (state_d)
      c_ST_LOAD: begin
        cmd_d   = req_use_dp_i ? c_CMD_LOAD_DP : c_CMD_LOAD_PC;
        baddr_d = req_addr_i;
        if (req_use_dp_i) begin
          dp_d     = req_addr_i;
          dp_vld_d = 1'b1;
        end else begin
          pc_d     = req_addr_i;
          pc_vld_d = 1'b1;
        end
      end
      c_ST_XFER: begin
        if (w_wr) begin
          cmd_d  = w_dp ? c_CMD_DP_WRITE : c_CMD_PC_WRITE;
          bnib_d = w_wdata[{w_nidx, 2'b00} +: 4];
        end else begin
          cmd_d  = w_dp ? c_CMD_DP_READ : c_CMD_PC_READ;
        end
        baddr_d   = w_ptr;
        cmd_idx_d = w_nidx;
        if (w_dp) begin
          dp_d = w_ptr + 20'd1;
        end else begin
          pc_d = w_ptr + 20'd1;
        end
      end
      c_ST_CONF: begin
        cmd_d   = c_CMD_CONFIGURE;
        baddr_d = req_addr_i;
      end
      c_ST_RST: begin
        cmd_d = c_CMD_RESET;
      end
      c_ST_DONE: begin
        done_d = 1'b1;
        err_d  = err_acc_d;
        rd_d   = rbuf_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge strobe_i) begin
    if (reset_i) begin
      op_q      <= c_OP_READ;
      use_dp_q  <= 1'b0;
      cnt_q     <= 4'd0;
      wdata_q   <= '0;
      cmd_idx_q <= 4'd0;
      pc_q      <= 20'd0;
      dp_q      <= 20'd0;
      pc_vld_q  <= 1'b0;
      dp_vld_q  <= 1'b0;
      cap_q     <= 1'b0;
      cap_idx_q <= 4'd0;
      rbuf_q    <= '0;
      err_acc_q <= 1'b0;
      cmd_q     <= c_CMD_NOP;
      baddr_q   <= 20'd0;
      bnib_q    <= 4'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= '0;
      ready_q   <= 1'b1;
    end else begin
      op_q      <= op_d;
      use_dp_q  <= use_dp_d;
      cnt_q     <= cnt_d;
      wdata_q   <= wdata_d;
      cmd_idx_q <= cmd_idx_d;
      pc_q      <= pc_d;
      dp_q      <= dp_d;
      pc_vld_q  <= pc_vld_d;
      dp_vld_q  <= dp_vld_d;
      cap_q     <= cap_d;
      cap_idx_q <= cap_idx_d;
      rbuf_q    <= rbuf_d;
      err_acc_q <= err_acc_d;
      cmd_q     <= cmd_d;
      baddr_q   <= baddr_d;
      bnib_q    <= bnib_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_q      <= rd_d;
      ready_q   <= ready_d;
    end
  end

  assign req_ready_o      = ready_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign rd_data_o        = rd_q;
  assign bus_command_o    = cmd_q;
  assign bus_address_o    = baddr_q;
  assign bus_nibble_out_o = bnib_q;

endmodule
`default_nettype wire

// File: tb/tb_hp48_bus_ctrl.sv
`default_nettype none
// tb_hp48_bus_ctrl - randomized requests against a RAM slave; expectations come
// from an address-level memory/pointer model and are checked by queue-driven monitors.
module tb_hp48_bus_ctrl;

  localparam logic [3:0] CMD_NOP       = 4'h0;
  localparam logic [3:0] CMD_PC_READ   = 4'h2;
  localparam logic [3:0] CMD_DP_READ   = 4'h3;
  localparam logic [3:0] CMD_PC_WRITE  = 4'h4;
  localparam logic [3:0] CMD_DP_WRITE  = 4'h5;
  localparam logic [3:0] CMD_LOAD_PC   = 4'h6;
  localparam logic [3:0] CMD_LOAD_DP   = 4'h7;
  localparam logic [3:0] CMD_CONFIGURE = 4'h8;
  localparam logic [3:0] CMD_RESET     = 4'h9;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_CONF  = 2'd2;
  localparam logic [1:0] OP_RST   = 2'd3;

  logic        strobe = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic        req_use_dp = 1'b0;
  logic [19:0] req_addr = 20'd0;
  logic [3:0]  req_count = 4'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        done;
  logic [63:0] rd_data;
  logic        err;
  logic [3:0]  bus_command;
  logic [19:0] bus_address;
  logic [3:0]  bus_nibble_out;
  logic [3:0]  bus_nibble_in = 4'd0;
  logic        bus_active;
  bit          inactive = 1'b0;

  hp48_bus_ctrl dut (
    .strobe_i         (strobe),
    .reset_i          (reset),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_op_i         (req_op),
    .req_use_dp_i     (req_use_dp),
    .req_addr_i       (req_addr),
    .req_count_i      (req_count),
    .req_wdata_i      (req_wdata),
    .done_o           (done),
    .rd_data_o        (rd_data),
    .err_o            (err),
    .bus_command_o    (bus_command),
    .bus_address_o    (bus_address),
    .bus_nibble_out_o (bus_nibble_out),
    .bus_nibble_in_i  (bus_nibble_in),
    .bus_active_i     (bus_active)
  );

  initial forever #5 strobe = ~strobe;

  assign bus_active = (bus_command != CMD_NOP) && !inactive;

  typedef struct {
    logic [3:0]  cmd;
    logic [19:0] addr;
    logic [3:0]  nib;
    bit          chk_addr;
    bit          chk_nib;
  } cmd_t;

  typedef struct {
    logic [63:0] rd;
    logic        err;
    int          lat;
  } done_t;

  cmd_t  exp_cmd[$];
  done_t exp_done[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    acc_cyc = 0;

  // Slave: a RAM with its own PC/DP pointers, driven only by bus commands.
  logic [3:0]  smem [1 << 20];
  logic [19:0] spc = 20'd0;
  logic [19:0] sdp = 20'd0;

  // Reference: flat nibble memory plus last-known slave pointers.
  logic [3:0]  rmem [1 << 20];
  logic [19:0] m_pc = 20'd0, m_dp = 20'd0;
  bit          m_pcv = 1'b0, m_dpv = 1'b0;

  always @(posedge strobe) cyc <= cyc + 1;

  always @(posedge strobe) begin
    case (bus_command)
      CMD_LOAD_PC:  spc <= bus_address;
      CMD_LOAD_DP:  sdp <= bus_address;
      CMD_PC_READ:  begin bus_nibble_in <= smem[spc]; spc <= spc + 20'd1; end
      CMD_DP_READ:  begin bus_nibble_in <= smem[sdp]; sdp <= sdp + 20'd1; end
      CMD_PC_WRITE: begin smem[spc] <= bus_nibble_out; spc <= spc + 20'd1; end
      CMD_DP_WRITE: begin smem[sdp] <= bus_nibble_out; sdp <= sdp + 20'd1; end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  cmd_t  mc;
  done_t md;
  always @(negedge strobe) begin
    if (!reset) begin
      if (bus_command != CMD_NOP) begin
        if (exp_cmd.size() == 0) begin
          chk("unexpected_cmd", 64'(bus_command), 64'(CMD_NOP));
        end else begin
          mc = exp_cmd.pop_front();
          chk("bus_command", 64'(bus_command), 64'(mc.cmd));
          if (mc.chk_addr) chk("bus_address", 64'(bus_address), 64'(mc.addr));
          if (mc.chk_nib)  chk("bus_nibble_out", 64'(bus_nibble_out), 64'(mc.nib));
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'(1'b0));
        end else begin
          md = exp_done.pop_front();
          chk("rd_data", rd_data, md.rd);
          chk("err", 64'(err), 64'(md.err));
          chk("done_latency", 64'(cyc - acc_cyc), 64'(md.lat));
        end
      end
    end
  end

  task automatic flush();
    exp_cmd.delete();
    exp_done.delete();
    inactive = 1'b0;
  endtask

  task automatic push_cmd(input logic [3:0] cmd, input logic [19:0] a, input logic [3:0] nib,
                          input bit ca, input bit cn);
    cmd_t c;
    c.cmd = cmd; c.addr = a; c.nib = nib; c.chk_addr = ca; c.chk_nib = cn;
    exp_cmd.push_back(c);
  endtask

  // Builds the expected bus trace and completion for one request, then drives it.
  // abort_after > 0 applies a reset that many cycles after acceptance.
  task automatic do_req(input logic [1:0] op, input bit dp, input logic [19:0] addr,
                        input logic [3:0] cnt, input logic [63:0] wd, input bit inact,
                        input int abort_after);
    done_t d;
    logic [19:0] a;
    bit hit;
    int n;
    int w;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge strobe); w++; end
    if (!req_ready) begin
      chk("ready_timeout", 64'(req_ready), 64'(1'b1));
      flush();
      return;
    end
    d.rd = '0; d.err = 1'b0; d.lat = 1;
    if (op == OP_READ || op == OP_WRITE) begin
      n = int'(cnt) + 1;
      hit = dp ? (m_dpv && m_dp == addr) : (m_pcv && m_pc == addr);
      if (!hit) push_cmd(dp ? CMD_LOAD_DP : CMD_LOAD_PC, addr, 4'd0, 1'b1, 1'b0);
      for (int i = 0; i < n; i++) begin
        a = addr + 20'(i);
        if (op == OP_WRITE) begin
          push_cmd(dp ? CMD_DP_WRITE : CMD_PC_WRITE, a, wd[4*i +: 4], 1'b1, 1'b1);
          rmem[a] = wd[4*i +: 4];
        end else begin
          push_cmd(dp ? CMD_DP_READ : CMD_PC_READ, a, 4'd0, 1'b1, 1'b0);
          d.rd[4*i +: 4] = rmem[a];
        end
      end
      if (dp) begin m_dp = addr + 20'(n); m_dpv = 1'b1; end
      else    begin m_pc = addr + 20'(n); m_pcv = 1'b1; end
      d.err = inact;
      d.lat = n + (hit ? 0 : 1) + ((op == OP_READ) ? 1 : 0);
    end else if (op == OP_CONF) begin
      push_cmd(CMD_CONFIGURE, addr, 4'd0, 1'b1, 1'b0);
    end else begin
      push_cmd(CMD_RESET, 20'd0, 4'd0, 1'b0, 1'b0);
    end
    exp_done.push_back(d);

    req_op = op; req_use_dp = dp; req_addr = addr; req_count = cnt; req_wdata = wd;
    inactive = inact;
    req_valid = 1'b1;
    @(posedge strobe);
    #1 acc_cyc = cyc;
    @(negedge strobe);
    req_valid = 1'b0;
    req_addr = $urandom;
    chk("ready_after_accept", 64'(req_ready), 64'(1'b0));

    if (abort_after > 0) begin
      repeat (abort_after - 1) @(negedge strobe);
      reset = 1'b1;
      @(posedge strobe);
      #1 flush();
      m_pcv = 1'b0; m_dpv = 1'b0;
      @(negedge strobe);
      chk("abort_cmd_nop", 64'(bus_command), 64'(CMD_NOP));
      chk("abort_ready", 64'(req_ready), 64'(1'b1));
      chk("abort_done", 64'(done), 64'(1'b0));
      @(negedge strobe);
      reset = 1'b0;
      repeat (25) @(negedge strobe);
      return;
    end

    w = 0;
    while (exp_done.size() != 0 && w < 100) begin @(negedge strobe); w++; end
    if (exp_done.size() != 0) begin
      chk("done_timeout", 64'(exp_done.size()), 64'(0));
      flush();
    end
    chk("cmd_leftover", 64'(exp_cmd.size()), 64'(0));
    exp_cmd.delete();
    inactive = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0]  op;
    bit          dp;
    logic [19:0] addr;
    int          r;
    for (int i = 0; i < (1 << 20); i++) begin
      smem[i] = 4'h0;
      rmem[i] = 4'h0;
    end

    repeat (3) @(posedge strobe);
    @(negedge strobe);
    chk("rst_cmd", 64'(bus_command), 64'(CMD_NOP));
    chk("rst_ready", 64'(req_ready), 64'(1'b1));
    chk("rst_done", 64'(done), 64'(1'b0));
    chk("rst_err", 64'(err), 64'(1'b0));
    chk("rst_rd", rd_data, 64'd0);
    chk("rst_addr", 64'(bus_address), 64'd0);
    chk("rst_nib", 64'(bus_nibble_out), 64'd0);
    reset = 1'b0;
    @(negedge strobe);

    do_req(OP_WRITE, 1'b0, 20'h80000, 4'd3, 64'h4321, 1'b0, 0);
    do_req(OP_READ,  1'b1, 20'h80000, 4'd3, 64'd0,    1'b0, 0);
    chk("T3_rd_low", 64'(rd_data[15:0]), 64'h4321);
    do_req(OP_READ,  1'b0, 20'h80004, 4'd0, 64'd0,    1'b0, 0);
    do_req(OP_WRITE, 1'b0, 20'hFFFFF, 4'd2, 64'h9AB,  1'b0, 0);
    do_req(OP_READ,  1'b0, 20'hFFFFF, 4'd1, 64'd0,    1'b0, 0);
    chk("T5_wrap_rd", 64'(rd_data[7:0]), 64'hAB);
    do_req(OP_READ,  1'b0, 20'h00001, 4'd0, 64'd0,    1'b0, 0);
    do_req(OP_READ,  1'b0, 20'h00002, 4'd2, 64'd0,    1'b1, 0);
    do_req(OP_CONF,  1'b0, 20'hC0000, 4'd0, 64'd0,    1'b0, 0);
    do_req(OP_RST,   1'b1, 20'h00000, 4'd0, 64'd0,    1'b0, 0);
    do_req(OP_READ,  1'b0, 20'h00003, 4'd15, 64'd0,   1'b0, 0);

    for (int k = 0; k < 160; k++) begin
      r  = $urandom_range(15, 0);
      op = (r < 6) ? OP_READ : (r < 12) ? OP_WRITE : (r < 14) ? OP_CONF : OP_RST;
      dp = 1'($urandom_range(1, 0));
      case ($urandom_range(3, 0))
        0, 1:    addr = dp ? m_dp : m_pc;
        2:       addr = 20'h80000 + 20'($urandom_range(63, 0));
        default: addr = 20'hFFFF0 + 20'($urandom_range(15, 0));
      endcase
      do_req(op, dp, addr, 4'($urandom_range(15, 0)), {$urandom, $urandom},
             ($urandom_range(15, 0) == 0), 0);
      if (k == 80) do_req(OP_READ, 1'b0, 20'h80010, 4'd15, 64'd0, 1'b0, 5);
    end
    do_req(OP_READ, 1'b1, 20'h80000, 4'd7, 64'd0, 1'b0, 0);

    repeat (5) @(negedge strobe);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
